// File: rtl/socaudio_mul_seq_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier.
// Holds the FSM state encoding, the partial-product shift amounts and the issue counts.
// Also holds the legal multiplier pipeline depth range.
package socaudio_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Left shift applied to each 16x16 partial product before accumulation
  localparam int unsigned PP0_SHIFT = 0;   // a_lo * b_lo
  localparam int unsigned PP1_SHIFT = 16;  // a_lo * b_hi
  localparam int unsigned PP2_SHIFT = 16;  // a_hi * b_lo
  localparam int unsigned PP3_SHIFT = 32;  // a_hi * b_hi

  localparam int unsigned ISSUE_CNT_LO = 3;  // low 32 bits only
  localparam int unsigned ISSUE_CNT_HI = 4;  // full 64-bit product

  localparam int unsigned MULT_LAT_MIN = 1;
  localparam int unsigned MULT_LAT_MAX = 3;

  function automatic logic [5:0] pp_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    return 6'(PP0_SHIFT);
      2'd1:    return 6'(PP1_SHIFT);
      2'd2:    return 6'(PP2_SHIFT);
      default: return 6'(PP3_SHIFT);
    endcase
  endfunction

endpackage

// File: rtl/socaudio_mul_seq_mult16.sv
// Unsigned 16x16->32 multiplier with a LATENCY-deep register pipeline.
// Latency: LATENCY enabled clocks; stages advance only while en_i is high (no backpressure).
// Ports: clk, reset (sync clear), en_i (advance), a_i/b_i operands, p_o product.
module socaudio_mul_seq_mult16 #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [31:0] pipe_q [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else if (en_i) begin
      pipe_q[0] <= {16'b0, a_i} * {16'b0, b_i};
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/socaudio_mul_sequencer.sv
// 32x32 unsigned multiplier built from one 16x16 multiplier, issuing 3 or 4 partial products.
// Latency: result valid N+MULT_LATENCY+1 clocks after accept (N=4 full, N=3 low half).
// Backpressure: result held until out_ready; no new accept until the clock after the handshake.
// Ports: clk/reset; in_valid/in_ready/in_a/in_b/in_hi request; flush cancel;
//        out_valid/out_ready/out_result response; busy = not idle.
module socaudio_mul_sequencer
  import socaudio_mul_seq_pkg::*;
#(
  parameter int MULT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_hi,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        busy
);

  if (MULT_LATENCY < int'(MULT_LAT_MIN) || MULT_LATENCY > int'(MULT_LAT_MAX)) begin : g_lat_chk
    $error("MULT_LATENCY out of range");
  end

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic        hi_q;
  logic [1:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] res_q;
  logic        last_q;
  logic        load_res;

  // Tags travel alongside the multiplier data; a flush clears them so stale
  // products left in the data pipeline are never accumulated.
  logic [MULT_LATENCY-1:0] tag_vld_q;
  logic [1:0]              tag_idx_q [MULT_LATENCY];

  logic        accept, issue, mult_en;
  logic [1:0]  last_idx;
  logic [15:0] op_a, op_b;
  logic [31:0] prod;
  logic        prod_vld;
  logic [1:0]  prod_idx;
  logic [63:0] prod_ext;

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_result = res_q;

  assign accept   = in_valid & in_ready & ~flush & ~reset;
  assign issue    = (state_q == ST_ISSUE) & ~flush;
  assign last_idx = hi_q ? 2'(ISSUE_CNT_HI - 1) : 2'(ISSUE_CNT_LO - 1);

  // Issue order 0..3 maps to {a_lo*b_lo, a_lo*b_hi, a_hi*b_lo, a_hi*b_hi}
  assign op_a = cnt_q[1] ? a_q[31:16] : a_q[15:0];
  assign op_b = cnt_q[0] ? b_q[31:16] : b_q[15:0];

  // Enable on issue clocks and while a product sits in a non-final stage
  always_comb begin
    mult_en = issue;
    for (int i = 0; i < MULT_LATENCY - 1; i++) mult_en = mult_en | tag_vld_q[i];
  end

  socaudio_mul_seq_mult16 #(
    .LATENCY (MULT_LATENCY)
  ) u_mult16 (
    .clk   (clk),
    .reset (reset),
    .en_i  (mult_en),
    .a_i   (op_a),
    .b_i   (op_b),
    .p_o   (prod)
  );

  assign prod_vld = tag_vld_q[MULT_LATENCY-1];
  assign prod_idx = tag_idx_q[MULT_LATENCY-1];
  assign prod_ext = {32'b0, prod} << pp_shift(prod_idx);

  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (accept) state_d = ST_ISSUE;
        ST_ISSUE: if (cnt_q == last_idx) state_d = ST_DRAIN;
        // last_q marks that the accumulator now holds the final sum
        ST_DRAIN: if (last_q) begin
          state_d  = ST_DONE;
          load_res = 1'b1;
        end
        ST_DONE:  if (out_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= ~flush & prod_vld & (prod_idx == last_idx);
      if (prod_vld && !flush) acc_q <= acc_q + prod_ext;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        hi_q  <= in_hi;
        cnt_q <= '0;
        acc_q <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (load_res) res_q <= hi_q ? acc_q : {32'b0, acc_q[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tag_vld_q <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) tag_idx_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      tag_idx_q[0] <= cnt_q;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

endmodule

// File: doc/socaudio_mul_sequencer.md
SOCAUDIO_MUL_SEQUENCER -- requirements
Module: socaudio_mul_sequencer

Interface
REQ-001 The block SHALL have parameter MULT_LATENCY, default 1, giving the 16x16 multiplier pipeline depth in clocks (legal 1..3).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operand request.
REQ-006 in_ready  out  1  high only in IDLE; accept = in_valid & in_ready & ~flush.
REQ-007 in_a  in  32  multiplicand, unsigned.
REQ-008 in_b  in  32  multiplier, unsigned.
REQ-009 in_hi  in  1  1 = full 64-bit product; 0 = low 32 bits only.
REQ-010 flush  in  1  synchronous cancel of any operation in flight.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_result  out  64  product; [63:32] forced 0 when captured in_hi=0.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 On accept, in_a, in_b and in_hi SHALL be captured; later changes on the inputs SHALL have no effect.
REQ-016 States SHALL be IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on accept, ISSUE->DRAIN after the last issue, DRAIN->DONE when the last product is accumulated, DONE->IDLE on out_valid & out_ready.
REQ-017 ISSUE SHALL present one 16x16 pair per clock, in order: PP0=a_lo*b_lo, PP1=a_lo*b_hi, PP2=a_hi*b_lo, then PP3=a_hi*b_hi only if in_hi=1 (N=4 issues), else N=3.
REQ-018 The multiplier enable SHALL be high exactly on issue clocks and on clocks needed to advance issued products through the pipeline.
REQ-019 The 64-bit accumulator SHALL clear on accept and add PP0<<0, PP1<<16, PP2<<16, PP3<<32 as each product emerges, with modulo-2^64 wrap.
REQ-020 For accept at edge T, out_valid SHALL first be high after edge T+N+MULT_LATENCY+1.
REQ-021 While out_valid=1 and out_ready=0, out_result and out_valid SHALL hold stable; in_ready SHALL stay 0.
REQ-022 in_ready SHALL be high the clock after the output handshake; no acceptance in the same clock as the output handshake.
REQ-023 flush SHALL force IDLE at the next edge from any state, drop out_valid, discard in-flight products, and win over a simultaneous in_valid.
REQ-024 flush in IDLE SHALL have no effect other than blocking acceptance in that clock.
REQ-025 Products still in the multiplier pipeline after a flush SHALL NOT be accumulated into any later operation.

Reset
REQ-026 Reset SHALL force IDLE; in_ready=1 after reset deassertion, out_valid=0, busy=0, out_result=0, accumulator=0, issue counter=0.
REQ-027 Reset mid-operation SHALL behave as flush, plus zero out_result; reset SHALL take priority over flush and in_valid.

Structure
REQ-028 Package socaudio_mul_seq_pkg SHALL hold the state enum, the partial-product shift constants (0, 16, 16, 32), the issue counts (3, 4) and the MULT_LATENCY bounds.
REQ-029 One sub-module socaudio_mul_seq_mult16 SHALL implement the unsigned 16x16->32 multiplier: MULT_LATENCY registers, an enable, and synchronous clear from reset.
REQ-030 The design SHALL instantiate exactly one socaudio_mul_seq_mult16 instance.

Verification
REQ-031 in_a=in_b=0xFFFFFFFF, in_hi=1, MULT_LATENCY=1, accept at T -> out_valid first high after T+6, out_result=0xFFFFFFFE00000001.
REQ-032 in_a=0x00012345, in_b=0x00010003, in_hi=0 -> out_valid after T+5, out_result=0x00000000234869CF.
REQ-033 Full multiply with out_ready held 0 for 10 clocks after out_valid -> out_result stable and in_ready=0 throughout; handshake on clock 11, in_ready=1 on the next clock.
REQ-034 flush at T+3 of a full multiply, then accept 7*6 (in_hi=1) -> first result never appears; out_result=0x000000000000002A.
REQ-035 Reset at T+2, with in_valid held high during reset -> after reset, out_valid=0, in_ready=1; no accept during reset; the next 3*5 gives 15.
REQ-036 MULT_LATENCY=3, full multiply 0x10000*0x10000 -> out_valid after T+8, out_result=0x0000000100000000.
